modinv_reduce_sequencer: RTL

//  Sequences the reduce phase of the modular invertor: repeats s <- s/2 or (s+q)/2 until k reaches 0.

---
 rtl/modinv_reduce_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/modinv_reduce_sequencer.sv
// Reduce-phase sequencer of the modular invertor: repeats s <- s/2 or (s+q)/2
// through the precalc and copy helpers until k reaches zero.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for ena; rdy=1
// PRE_ISSUE  | one-cycle pre_ena pulse to the reduce-precalc helper
// PRE_WAIT   | waiting for pre_rdy; timeout counter running
// DECIDE     | sample k_is_nul / s_is_odd; stop or pick u/v for the copy
// COPY_ISSUE | one-cycle cpy_ena pulse to the copy helper
// COPY_WAIT  | waiting for cpy_rdy; then k--, iter++
// DONE       | one-cycle finish state; rdy=1, a new ena is accepted here too
module modinv_reduce_sequencer #(
    parameter int K_NUM_BITS     = 10,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_BITS       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    output logic                  rdy,
    output logic                  err,
    input  logic [K_NUM_BITS-1:0] k_in,
    output logic [K_NUM_BITS-1:0] k_cur,
    output logic [K_NUM_BITS-1:0] iter_cnt,
    output logic                  pre_ena,
    input  logic                  pre_rdy,
    input  logic                  s_is_odd,
    input  logic                  k_is_nul,
    output logic                  cpy_ena,
    output logic                  cpy_sel,
    input  logic                  cpy_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_ISSUE,
        S_PRE_WAIT,
        S_DECIDE,
        S_COPY_ISSUE,
        S_COPY_WAIT,
        S_DONE
    } state_t;

    // Abort fires on the last of TIMEOUT_CYCLES wait cycles.
    localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [K_NUM_BITS-1:0]   k_nxt;
    logic [K_NUM_BITS-1:0]   iter_nxt;
    logic [TMO_BITS-1:0]     tmo_cnt;
    logic [TMO_BITS-1:0]     tmo_nxt;
    logic                    err_nxt;
    logic                    sel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            k_cur    <= '0;
            iter_cnt <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
            cpy_sel  <= 1'b0;
        end else begin
            state    <= state_nxt;
            k_cur    <= k_nxt;
            iter_cnt <= iter_nxt;
            tmo_cnt  <= tmo_nxt;
            err      <= err_nxt;
            cpy_sel  <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k_cur;
        iter_nxt  = iter_cnt;
        tmo_nxt   = tmo_cnt;
        err_nxt   = err;
        sel_nxt   = cpy_sel;
        rdy       = 1'b0;
        pre_ena   = 1'b0;
        cpy_ena   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                rdy = 1'b1;
                if (ena) begin
                    k_nxt     = k_in;
                    iter_nxt  = '0;
                    err_nxt   = 1'b0;
                    state_nxt = S_PRE_ISSUE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end

            S_PRE_ISSUE: begin
                pre_ena   = 1'b1;
                tmo_nxt   = '0;
                state_nxt = S_PRE_WAIT;
            end

            S_PRE_WAIT: begin
                if (pre_rdy) begin
                    state_nxt = S_DECIDE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_BITS'(1);
                end
            end

            S_DECIDE: begin
                if (k_is_nul) begin
                    state_nxt = S_DONE;
                end else begin
                    sel_nxt   = s_is_odd;
                    state_nxt = S_COPY_ISSUE;
                end
            end

            S_COPY_ISSUE: begin
                cpy_ena   = 1'b1;
                tmo_nxt   = '0;
                state_nxt = S_COPY_WAIT;
            end

            S_COPY_WAIT: begin
                if (cpy_rdy) begin
                    // Guarded so a misbehaving helper flag can never wrap k.
                    if (k_cur != '0) begin
                        k_nxt = k_cur - K_NUM_BITS'(1);
                    end
                    iter_nxt  = iter_cnt + K_NUM_BITS'(1);
                    state_nxt = S_PRE_ISSUE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmo_nxt = tmo_cnt + TMO_BITS'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
